// File: rtl/cpu_run_controller.sv
// Run sequencer for the 3-bit accumulator CPU: streams the program into imem, then gates CPU reset/enable.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
//
// state | meaning
// IDLE  | no program; waiting for the first word
// LOAD  | streaming words into imem
// READY | program loaded, CPU held in reset
// CLEAR | one cycle: CPU samples its reset, counters cleared
// RUN   | CPU free-running until RUN_LIMIT instructions
// PAUSE | CPU frozen, counters hold
// STEP  | one instruction executed, then back to PAUSE
// DONE  | RUN_LIMIT instructions executed
module cpu_run_controller #(
   parameter int PROG_DEPTH = 8,
   parameter int ADDR_W     = 3,
   parameter int RUN_LIMIT  = 8,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
`ifdef BREAKPOINT_EN
   input  logic              bp_valid,
   input  logic [ADDR_W-1:0] bp_addr,
   output logic              bp_hit,
`endif
   input  logic              load_valid,
   input  logic [2:0]        load_data,
   output logic              load_ready,
   input  logic              start,
   input  logic              halt_req,
   input  logic              step,
   input  logic              reload,
   output logic              imem_wr_en,
   output logic [ADDR_W-1:0] imem_wr_addr,
   output logic [2:0]        imem_wr_data,
   output logic              cpu_reset,
   output logic              cpu_en,
   output logic [ADDR_W-1:0] exec_pc,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              busy,
   output logic              done,
   output logic              prog_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_READY, S_CLEAR, S_RUN, S_PAUSE, S_STEP, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(RUN_LIMIT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] load_ptr;
   logic              accept;
   logic [CNT_W-1:0]  count_inc;
   logic [ADDR_W-1:0] pc_inc;
   logic              limit_hit;
   logic              bp_run;
   logic              bp_clear;

   assign load_ready = (state == S_IDLE) || (state == S_LOAD);
   assign cpu_en     = (state == S_CLEAR) || (state == S_RUN) || (state == S_STEP);
   assign cpu_reset  = (state == S_IDLE) || (state == S_LOAD) || (state == S_READY) ||
                       (state == S_CLEAR);
   assign busy       = (state == S_CLEAR) || (state == S_RUN) || (state == S_STEP) ||
                       (state == S_PAUSE);
   assign done       = (state == S_DONE);

   assign accept       = load_valid & load_ready;
   assign imem_wr_en   = accept;
   assign imem_wr_addr = load_ptr;
   assign imem_wr_data = load_data;

   assign count_inc = cycle_count + 1'b1;
   assign pc_inc    = exec_pc + 1'b1;
   assign limit_hit = (count_inc == LIMIT);

`ifdef BREAKPOINT_EN
   // Breakpoint stops before the instruction at bp_addr is executed.
   assign bp_run   = bp_valid && (pc_inc == bp_addr);
   assign bp_clear = bp_valid && (bp_addr == '0);
`else
   assign bp_run   = 1'b0;
   assign bp_clear = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         load_ptr    <= '0;
         exec_pc     <= '0;
         cycle_count <= '0;
         prog_err    <= 1'b0;
`ifdef BREAKPOINT_EN
         bp_hit      <= 1'b0;
`endif
      end else begin
         prog_err <= 1'b0;
`ifdef BREAKPOINT_EN
         bp_hit   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (start) prog_err <= 1'b1;
               if (accept) begin
                  state    <= S_LOAD;
                  load_ptr <= load_ptr + 1'b1;
               end
            end
            S_LOAD: begin
               if (start) prog_err <= 1'b1;
               if (accept) begin
                  if (load_ptr == LAST_ADDR) begin
                     state    <= S_READY;
                     load_ptr <= '0;
                  end else begin
                     load_ptr <= load_ptr + 1'b1;
                  end
               end
            end
            S_READY: begin
               if (reload) begin
                  state    <= S_IDLE;
                  load_ptr <= '0;
               end else if (start) begin
                  state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               cycle_count <= '0;
               exec_pc     <= '0;
               if (bp_clear) begin
                  state <= S_PAUSE;
`ifdef BREAKPOINT_EN
                  bp_hit <= 1'b1;
`endif
               end else begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               cycle_count <= count_inc;
               exec_pc     <= pc_inc;
               if (limit_hit) begin
                  state <= S_DONE;
               end else if (bp_run) begin
                  state <= S_PAUSE;
`ifdef BREAKPOINT_EN
                  bp_hit <= 1'b1;
`endif
               end else if (halt_req) begin
                  state <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (reload) begin
                  state    <= S_IDLE;
                  load_ptr <= '0;
               end else if (start) begin
                  state <= S_RUN;
               end else if (step) begin
                  state <= S_STEP;
               end
            end
            S_STEP: begin
               cycle_count <= count_inc;
               exec_pc     <= pc_inc;
               state       <= limit_hit ? S_DONE : S_PAUSE;
            end
            S_DONE: begin
               if (reload) begin
                  state    <= S_IDLE;
                  load_ptr <= '0;
               end else if (start) begin
                  state <= S_CLEAR;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed testbench for cpu_run_controller: load, run, halt/step/resume, limit, reload, reset, breakpoint.
// Breakpoint scenario is compiled only when BREAKPOINT_EN is defined.
module tb_cpu_run_controller;

   logic       clk = 1'b0;
   logic       reset, load_valid, start, halt_req, step, reload;
   logic [2:0] load_data;
   logic       load_ready, imem_wr_en, cpu_reset, cpu_en, busy, done, prog_err;
   logic [2:0] imem_wr_addr, imem_wr_data, exec_pc;
   logic [3:0] cycle_count;
`ifdef BREAKPOINT_EN
   logic       bp_valid, bp_hit;
   logic [2:0] bp_addr;
`endif

   int checks = 0;
   int errors = 0;

   logic [2:0] words [8] = '{3'd0, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd2, 3'd3};

   always #5 clk = ~clk;

   cpu_run_controller dut (
      .clk(clk), .reset(reset),
`ifdef BREAKPOINT_EN
      .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .start(start), .halt_req(halt_req), .step(step), .reload(reload),
      .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
      .cpu_reset(cpu_reset), .cpu_en(cpu_en), .exec_pc(exec_pc),
      .cycle_count(cycle_count), .busy(busy), .done(done), .prog_err(prog_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Plain stimulus: streams the 8 program words back to back from IDLE.
   task automatic load_words();
      for (int i = 0; i < 8; i++) begin
         load_valid = 1'b1;
         load_data  = words[i];
         cyc();
      end
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      checks++;
      if ({cpu_reset, cpu_en, load_ready, busy, done, prog_err} !== 6'b101000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 101000", {cpu_reset, cpu_en, load_ready, busy, done, prog_err});
      end
      checks++;
      if (cycle_count !== 4'd0 || exec_pc !== 3'd0) begin
         errors++;
         $display("FAIL reset_counters: got count=%0d pc=%0d expected 0 0", cycle_count, exec_pc);
      end
   endtask

   task automatic test_load();
      int writes = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            load_valid = 1'b0;
            #1;
            checks++;
            if (imem_wr_en !== 1'b0) begin
               errors++;
               $display("FAIL load_gap_wr_en: got %b expected 0", imem_wr_en);
            end
            cyc();
         end
         load_valid = 1'b1;
         load_data  = words[i];
         #1;
         if (imem_wr_en === 1'b1) writes++;
         checks++;
         if (imem_wr_en !== 1'b1 || imem_wr_addr !== 3'(i) || imem_wr_data !== words[i]) begin
            errors++;
            $display("FAIL load_word%0d: got en=%b addr=%0d data=%0d expected 1 %0d %0d",
                     i, imem_wr_en, imem_wr_addr, imem_wr_data, i, words[i]);
         end
         cyc();
      end
      // load_valid still high in READY: must be ignored
      checks++;
      if (imem_wr_en !== 1'b0 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_ready_after: got en=%b ready=%b expected 0 0", imem_wr_en, load_ready);
      end
      load_valid = 1'b0;
      checks++;
      if (writes !== 8 || done !== 1'b0 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
         errors++;
         $display("FAIL load_summary: got writes=%0d done=%b busy=%b cpu_reset=%b expected 8 0 0 1",
                  writes, done, busy, cpu_reset);
      end
   endtask

   task automatic test_run();
      start = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if (cpu_reset !== 1'b1 || cpu_en !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL run_clear: got rst=%b en=%b busy=%b expected 1 1 1", cpu_reset, cpu_en, busy);
      end
      cyc();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (cpu_en !== 1'b1 || cpu_reset !== 1'b0 || cycle_count !== 4'(k) || exec_pc !== 3'(k)) begin
            errors++;
            $display("FAIL run_cycle%0d: got en=%b rst=%b count=%0d pc=%0d expected 1 0 %0d %0d",
                     k, cpu_en, cpu_reset, cycle_count, exec_pc, k, k);
         end
         cyc();
      end
      checks++;
      if (done !== 1'b1 || cpu_en !== 1'b0 || cycle_count !== 4'd8 || exec_pc !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL run_done: got done=%b en=%b count=%0d pc=%0d busy=%b expected 1 0 8 0 0",
                  done, cpu_en, cycle_count, exec_pc, busy);
      end
   endtask

   task automatic test_halt_step();
      int en_cycles = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      checks++;
      if (cpu_en !== 1'b0 || cycle_count !== 4'd3 || busy !== 1'b1 || exec_pc !== 3'd3) begin
         errors++;
         $display("FAIL halt_pause: got en=%b count=%0d busy=%b pc=%0d expected 0 3 1 3",
                  cpu_en, cycle_count, busy, exec_pc);
      end
      cyc();
      checks++;
      if (cycle_count !== 4'd3) begin
         errors++;
         $display("FAIL halt_hold: got count=%0d expected 3", cycle_count);
      end
      for (int s = 0; s < 2; s++) begin
         step = 1'b1;
         cyc();
         step = 1'b0;
         if (cpu_en === 1'b1) en_cycles++;
         cyc();
         if (cpu_en === 1'b1) en_cycles++;
         cyc();
         if (cpu_en === 1'b1) en_cycles++;
      end
      checks++;
      if (en_cycles !== 2 || cycle_count !== 4'd5) begin
         errors++;
         $display("FAIL step_two: got en_cycles=%0d count=%0d expected 2 5", en_cycles, cycle_count);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      en_cycles = 0;
      for (int k = 0; k < 3; k++) begin
         if (cpu_en === 1'b1) en_cycles++;
         cyc();
      end
      checks++;
      if (en_cycles !== 3 || done !== 1'b1 || cycle_count !== 4'd8 || cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL resume_done: got en_cycles=%0d done=%b count=%0d en=%b expected 3 1 8 0",
                  en_cycles, done, cycle_count, cpu_en);
      end
   endtask

   task automatic test_limit_over_halt();
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      repeat (7) cyc();
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== 4'd8) begin
         errors++;
         $display("FAIL limit_vs_halt: got done=%b busy=%b count=%0d expected 1 0 8", done, busy, cycle_count);
      end
   endtask

   task automatic test_reload();
      reload = 1'b1;
      cyc();
      reload = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL reload_idle: got ready=%b rst=%b done=%b en=%b expected 1 1 0 0",
                  load_ready, cpu_reset, done, cpu_en);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if (prog_err !== 1'b1 || cpu_en !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL prog_err_pulse: got err=%b en=%b ready=%b expected 1 0 1", prog_err, cpu_en, load_ready);
      end
      cyc();
      checks++;
      if (prog_err !== 1'b0) begin
         errors++;
         $display("FAIL prog_err_clear: got %b expected 0", prog_err);
      end
      load_valid = 1'b1;
      load_data  = 3'd6;
      #1;
      checks++;
      if (imem_wr_en !== 1'b1 || imem_wr_addr !== 3'd0) begin
         errors++;
         $display("FAIL reload_addr0: got en=%b addr=%0d expected 1 0", imem_wr_en, imem_wr_addr);
      end
      cyc();
      for (int i = 1; i < 8; i++) begin
         load_data = words[i];
         cyc();
      end
      load_valid = 1'b0;
      checks++;
      if (load_ready !== 1'b0) begin
         errors++;
         $display("FAIL reload_ready: got ready=%b expected 0", load_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks++;
      if (cpu_en !== 1'b0 || cpu_reset !== 1'b1 || cycle_count !== 4'd0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_run: got en=%b rst=%b count=%0d ready=%b expected 0 1 0 1",
                  cpu_en, cpu_reset, cycle_count, load_ready);
      end
   endtask

`ifdef BREAKPOINT_EN
   task automatic test_breakpoint();
      int hits = 0;
      load_words();
      bp_valid = 1'b1;
      bp_addr  = 3'd5;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (6) cyc();
      checks++;
      if (bp_hit !== 1'b1 || exec_pc !== 3'd5 || cycle_count !== 4'd5 || cpu_en !== 1'b0) begin
         errors++;
         $display("FAIL bp_pause: got hit=%b pc=%0d count=%0d en=%b expected 1 5 5 0",
                  bp_hit, exec_pc, cycle_count, cpu_en);
      end
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (bp_hit === 1'b1) hits++;
         cyc();
      end
      if (bp_hit === 1'b1) hits++;
      checks++;
      if (hits !== 0 || done !== 1'b1 || cycle_count !== 4'd8) begin
         errors++;
         $display("FAIL bp_resume: got hits=%0d done=%b count=%0d expected 0 1 8", hits, done, cycle_count);
      end
      bp_valid = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_data = 3'd0;
      start = 1'b0; halt_req = 1'b0; step = 1'b0; reload = 1'b0;
`ifdef BREAKPOINT_EN
      bp_valid = 1'b0; bp_addr = 3'd0;
`endif
      test_reset();
      test_load();
      test_run();
      test_halt_step();
      test_limit_over_halt();
      test_reload();
      test_reset_mid_run();
`ifdef BREAKPOINT_EN
      test_breakpoint();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Sequencer for the 3-bit accumulator CPU.
- Loads the 8-word instruction memory through a valid/ready stream.
- Then drives the CPU's synchronous reset and clock enable to run a program for a bounded number of instruction cycles.
- Supports halt, single-step, resume and re-run.
- Sits between the host/testbench and the CPU core plus its instruction memory write port.

Parameters:
PROG_DEPTH, 8, number of instruction words loaded per program.
ADDR_W, 3, instruction address width.
RUN_LIMIT, 8, executed instruction cycles per run before done.
CNT_W, 4, cycle_count width; must hold RUN_LIMIT.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high; resets the controller only.
load_valid  input  1  host instruction word valid.
load_data  input  3  instruction word {opcode[1:0], data}.
load_ready  output  1  controller accepts a word this cycle.
start  input  1  begin run (READY/DONE) or resume (PAUSE).
halt_req  input  1  pause a run.
step  input  1  execute one instruction while paused.
reload  input  1  discard the program and return to IDLE.
imem_wr_en  output  1  instruction memory write strobe.
imem_wr_addr  output  ADDR_W  write address.
imem_wr_data  output  3  write data.
cpu_reset  output  1  drives the CPU's synchronous reset.
cpu_en  output  1  CPU clock enable; the CPU advances only on edges where cpu_en=1.
exec_pc  output  ADDR_W  shadow of the CPU's pc: address of the next instruction to execute.
cycle_count  output  CNT_W  instructions executed in the current run.
busy  output  1  high in CLEAR, RUN, STEP and PAUSE.
done  output  1  high in DONE.
prog_err  output  1  one-cycle pulse when start arrives in IDLE or LOAD.

Behaviour:
- Moore FSM with states IDLE, LOAD, READY, CLEAR, RUN, PAUSE, STEP, DONE.
- cpu_en, cpu_reset, busy, done and load_ready decode from the state register only.
- Reset values: state=IDLE, load_ptr=0, exec_pc=0, cycle_count=0, prog_err=0, cpu_en=0, cpu_reset=1.
- load_ready=1 only in IDLE and LOAD.
- Load accept: load_valid & load_ready.
  - On accept: imem_wr_en=1 combinationally, imem_wr_addr=load_ptr, imem_wr_data=load_data.
  - On accept: load_ptr increments.
  - When not accepting: imem_wr_en=0.
- IDLE: first accept -> LOAD.
- LOAD: accept at load_ptr=PROG_DEPTH-1 -> READY; load_ptr wraps to 0.
- Valid gaps never write. start in IDLE/LOAD -> prog_err pulse, no state change.
- READY: start -> CLEAR. load_valid is ignored.
- CLEAR (1 cycle):
  - cpu_reset=1, cpu_en=1, so the CPU samples its reset.
  - cycle_count<=0, exec_pc<=0.
  - Next state RUN.
- cpu_reset=1 in IDLE, LOAD, READY and CLEAR; 0 otherwise.
- RUN: cpu_en=1. Each RUN cycle increments cycle_count and exec_pc; exec_pc wraps modulo 2^ADDR_W, matching the CPU pc.
  - Incremented count == RUN_LIMIT -> DONE.
  - Otherwise halt_req -> PAUSE. cpu_en is 0 from the next cycle.
- PAUSE: cpu_en=0; counters hold.
  - start -> RUN.
  - Otherwise step -> STEP.
- STEP (1 cycle): cpu_en=1; counters increment.
  - Next state is DONE if the limit is reached, else PAUSE.
  - step held high yields one instruction per two cycles.
- DONE: cpu_en=0; counters hold; start -> CLEAR (re-run the same program).
- reload in READY, PAUSE or DONE -> IDLE, load_ptr=0; CPU held in reset. reload is ignored elsewhere.
- Priorities:
  - reset > everything.
  - limit reached > halt_req.
  - reload > start > step.
- reset mid-RUN: cpu_en=0 and cpu_reset=1 from the next cycle; the program must be reloaded.

Optional Feature:
Macro BREAKPOINT_EN.
- Defined:
  - Adds inputs bp_valid (1) and bp_addr (ADDR_W), and output bp_hit (1-cycle pulse).
  - In RUN, if bp_valid and the post-increment exec_pc==bp_addr and the limit is not reached -> PAUSE with bp_hit=1. The instruction at bp_addr is not executed.
  - CLEAR with bp_valid and bp_addr==0 -> PAUSE with bp_hit=1.
  - STEP and resume-from-PAUSE execute the breakpointed instruction without re-triggering.
- Undefined: ports absent; no breakpoint logic.

Test Plan:
- Reset, stream 8 words 0,3,2,5,4,1,2,3 with one idle cycle between words 3 and 4 -> imem_wr_addr 0..7, exactly 8 writes, load_ready=0 after the 8th, done=0, busy=0.
- start from READY -> 1 cycle with cpu_reset=1 and cpu_en=1, then 8 cycles with cpu_en=1 and cycle_count 1..8, exec_pc back to 0, done=1, cpu_en=0.
- halt_req after 3 RUN cycles -> cpu_en=0, cycle_count=3; two step pulses -> exactly two cpu_en cycles, count=5; start -> runs 3 more, done at 8.
- halt_req in the same cycle the count reaches 8 -> DONE (not PAUSE). start in IDLE -> prog_err pulse, cpu_en stays 0.
- reload in DONE -> IDLE, load_ready=1, next write at addr 0. reset during RUN -> next cycle cpu_en=0, cpu_reset=1, cycle_count=0.
- BREAKPOINT_EN, bp_addr=5 -> PAUSE with exec_pc=5, cycle_count=5, bp_hit pulse; start -> completes to 8 without a second hit.
